// File: rtl/key_pkg.sv
// Shared types and helpers for the key event encoder: the queued event record
// and the lowest-index priority encode used by both the arbiter and held_idx.
package key_pkg;

  // Upper bound on the key count; the top zero-extends its vectors to this width.
  localparam int KEY_MAX_KEYS  = 64;
  localparam int KEY_IDX_MAX_W = 6;

  typedef struct packed {
    logic                     rel;
    logic [KEY_IDX_MAX_W-1:0] idx;
  } key_evt_t;

  function automatic logic [KEY_IDX_MAX_W-1:0] key_lowest_idx(input logic [KEY_MAX_KEYS-1:0] vec);
    logic [KEY_IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = KEY_MAX_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key line: two-flop synchroniser, stability counter, debounced level and
// single-cycle rise/fall pulses registered on the edge the level changes.
module key_debounce
  import key_pkg::*;
#(
  parameter int  DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the edge the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d  = '0;
    deb_d  = deb_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d  = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= key_i;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/key_event_encoder.sv
// Debounced key press/release events queued in a small FIFO with a valid/ready
// drain, plus a registered lowest-index view of the held keys.
module key_event_encoder
  import key_pkg::*;
#(
  parameter int  N_KEYS          = 4,
  parameter int  DEBOUNCE_CYCLES = 16,
  parameter int  FIFO_DEPTH      = 4,
  parameter bit  REPORT_RELEASE  = 1'b0,
  localparam int IDX_W           = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [IDX_W-1:0]  evt_idx,
  output logic              evt_release,
  output logic              held_any,
  output logic [IDX_W-1:0]  held_idx,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [N_KEYS-1:0] deb, rise, fall, rel_set;
  logic [N_KEYS-1:0] press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
  logic [N_KEYS-1:0] clr_press, clr_rel;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  key_evt_t          mem_q [FIFO_DEPTH];
  key_evt_t          push_evt, head_evt;
  logic              empty, full, pop, push, cand;
  logic              ovf_q, ovf_d, ovf_set;
  logic              held_any_q;
  logic [IDX_W-1:0]  held_idx_q;
  logic              unused_head_bits;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_i  (keys[gi]),
        .deb_o  (deb[gi]),
        .rise_o (rise[gi]),
        .fall_o (fall[gi])
      );
    end
  endgenerate

  assign rel_set = REPORT_RELEASE ? fall : '0;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign pop     = ~empty & evt_ready;

  // Presses outrank releases; a full FIFO only accepts when it pops too.
  always_comb begin
    push_evt  = '0;
    cand      = 1'b0;
    clr_press = '0;
    clr_rel   = '0;
    if (|press_pend_q) begin
      cand         = 1'b1;
      push_evt.idx = key_lowest_idx(KEY_MAX_KEYS'(press_pend_q));
    end else if (|rel_pend_q) begin
      cand         = 1'b1;
      push_evt.rel = 1'b1;
      push_evt.idx = key_lowest_idx(KEY_MAX_KEYS'(rel_pend_q));
    end
    push = cand & (~full | pop);
    if (push) begin
      if (|press_pend_q) clr_press = press_pend_q & (~press_pend_q + N_KEYS'(1));
      else               clr_rel   = rel_pend_q & (~rel_pend_q + N_KEYS'(1));
    end
  end

  always_comb begin
    press_pend_d = (press_pend_q & ~clr_press) | rise;
    rel_pend_d   = (rel_pend_q & ~clr_rel) | rel_set;
    ovf_set      = |(press_pend_q & ~clr_press & rise) | |(rel_pend_q & ~clr_rel & rel_set);
    ovf_d        = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      held_any_q   <= 1'b0;
      held_idx_q   <= '0;
    end else begin
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      held_any_q   <= |deb;
      held_idx_q   <= IDX_W'(key_lowest_idx(KEY_MAX_KEYS'(deb)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_evt;
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head_evt         = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign unused_head_bits = ^head_evt.idx;
  assign evt_valid        = ~empty;
  assign evt_idx          = empty ? '0 : IDX_W'(head_evt.idx);
  assign evt_release      = REPORT_RELEASE & ~empty & head_evt.rel;
  assign held_any         = held_any_q;
  assign held_idx         = held_idx_q;
  assign overflow         = ovf_q;

endmodule
